// File: rtl/fwd_sb_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// Holds the in-flight entry struct and the register-file select code.
package fwd_sb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  isLoad;
  } fwdEntry_t;

endpackage

// File: rtl/fwd_sb_match.sv
// Per-port priority matcher: youngest in-flight writer of addr wins.
// Ports: stages (entries), en/addr (source), sel (forward), notReady.
module fwd_sb_match
  import fwd_sb_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = 2
) (
  input  fwdEntry_t [NUM_STAGES-1:0] stages,
  input  logic                       en,
  input  logic [REG_ADDR_W-1:0]      addr,
  output logic [SEL_W-1:0]           sel,
  output logic                       notReady
);

  logic hit;
  logic hitLoad;
  logic ready;
  int   hitIdx;

  // Scan oldest to youngest so the last hit kept is the youngest.
  always_comb begin
    hit     = 1'b0;
    hitLoad = 1'b0;
    hitIdx  = 0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (en && stages[s].valid &&
          stages[s].regwrite &&
          (stages[s].rd != '0) &&
          (stages[s].rd == addr)) begin
        hit     = 1'b1;
        hitLoad = stages[s].isLoad;
        hitIdx  = s;
      end
    end
  end

  always_comb begin
    ready = hitLoad ? (hitIdx >= LOAD_READY_STAGE)
                    : (hitIdx >= 1);
    sel      = SEL_W'(FWD_SEL_RF);
    notReady = 1'b0;
    if (hit && ready) begin
      sel = SEL_W'(hitIdx + 1);
    end else if (hit) begin
      notReady = 1'b1;
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight producers, picks bypass or stall.
// Optional stall counter enabled by macro FWD_SB_PERF_CNT_EN.
module forward_scoreboard
  import fwd_sb_pkg::*;
#(
  parameter int NUM_RD_PORTS     = 4,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 2,
  localparam int SEL_W = $clog2(NUM_STAGES + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 issue_valid_i,
  input  logic [REG_ADDR_W-1:0]                issue_rd_i,
  input  logic                                 issue_regwrite_i,
  input  logic                                 issue_is_load_i,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0]   rs_addr_i,
  input  logic [NUM_RD_PORTS-1:0]              rs_en_i,
  input  logic                                 flush_i,
  output logic [NUM_RD_PORTS*SEL_W-1:0]        fwd_sel_o,
  output logic                                 stall_o,
  output logic [15:0]                          stall_cnt_o
);

  fwdEntry_t [NUM_STAGES-1:0] stages;
  fwdEntry_t                  issueEntry;
  logic [NUM_RD_PORTS-1:0]    notReady;
  logic                       doIssue;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gPort
    fwd_sb_match #(
      .NUM_STAGES       (NUM_STAGES),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SEL_W            (SEL_W)
    ) uMatch (
      .stages   (stages),
      .en       (rs_en_i[p]),
      .addr     (rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
      .sel      (fwd_sel_o[p*SEL_W +: SEL_W]),
      .notReady (notReady[p])
    );
  end

  assign stall_o = issue_valid_i & (|notReady);

  // Flush beats stall: a flushed slot always becomes a bubble.
  assign doIssue = issue_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    issueEntry          = '0;
    issueEntry.valid    = 1'b1;
    issueEntry.rd       = issue_rd_i;
    issueEntry.regwrite = issue_regwrite_i;
    issueEntry.isLoad   = issue_is_load_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stages <= '0;
    end else begin
      stages[0] <= doIssue ? issueEntry : '0;
      for (int s = 1; s < NUM_STAGES; s++) begin
        stages[s] <= stages[s-1];
      end
    end
  end

`ifdef FWD_SB_PERF_CNT_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stallCnt <= '0;
    end else if (stall_o && !flush_i &&
                 (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign stall_cnt_o = stallCnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
